// File: rtl/spi_flash_burst_reader.sv
// spi_flash_burst_reader
//   Multi-die sequential flash reader. Splits the inclusive byte range
//   [start_addr..end_addr] into bursts of up to MAX_BURST bytes, never
//   crossing a die boundary and never exceeding the free space of the local
//   byte FIFO. Bursts go to the QSPI controller over a valid/ready command
//   channel; returned bytes are buffered in the FIFO for the host.
// Ports
//   system_clk / system_reset      : clock, async active-high reset
//   start_flag, start_addr,
//   end_addr, mode, abort          : host request (mode 0/1/2 = single/dual/quad)
//   busy, read_finish, err         : host status (finish/err are 1-cycle pulses)
//   cmd_valid/ready/die/addr/
//   len/mode                       : burst command channel to the controller
//   rx_valid, rx_data, rx_last     : returned bytes from the controller
//   read_req, fifo_dataOut,
//   empty, full, fifo_level        : host-side FIFO pop interface
module spi_flash_burst_reader #(
  parameter int ADDR_W     = 32,
  parameter int DIE_ADDR_W = 25,
  parameter int DIE_CNT    = 2,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 64,
  localparam int DIE_W     = (DIE_CNT > 1) ? $clog2(DIE_CNT) : 1,
  localparam int LEN_W     = $clog2(MAX_BURST + 1),
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  system_clk,
  input  logic                  system_reset,
  input  logic                  start_flag,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  input  logic [1:0]            mode,
  input  logic                  abort,
  output logic                  busy,
  output logic                  read_finish,
  output logic                  err,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [DIE_W-1:0]      cmd_die,
  output logic [DIE_ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]      cmd_len,
  output logic [1:0]            cmd_mode,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_last,
  input  logic                  read_req,
  output logic [7:0]            fifo_dataOut,
  output logic                  empty,
  output logic                  full,
  output logic [LVL_W-1:0]      fifo_level
);

  // Address arithmetic is one bit wider than ADDR_W so curr can step past
  // an end_addr at the top of the address space without wrapping.
  localparam int CW    = ADDR_W + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DIE_SIZE    = CW'(1) << DIE_ADDR_W;
  localparam logic [CW-1:0] TOTAL_BYTES = CW'(DIE_CNT) << DIE_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT_DATA,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         curr_q, curr_d;
  logic [CW-1:0]         last_q, last_d;
  logic [1:0]            mode_q, mode_d;
  logic [LEN_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  busy_q, busy_d;
  logic                  finish_q, finish_d;
  logic                  err_q, err_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [DIE_W-1:0]      cmd_die_q, cmd_die_d;
  logic [DIE_ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]      cmd_len_q, cmd_len_d;

  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [7:0]            dout_q, dout_d;

  logic                  push_req, push, pop;
  logic                  full_w, empty_w;
  logic [CW-1:0]         remain, die_room, credit, len_w;
  logic [LEN_W-1:0]      issue_len;

  assign full_w   = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty_w  = (level_q == '0);
  assign push_req = (state_q == S_WAIT_DATA) && rx_valid;
  assign push     = push_req && !full_w;
  assign pop      = read_req && !empty_w;

  // Burst length: smallest of burst cap, bytes left, bytes left in this die
  // and free FIFO space. Only one burst is ever outstanding, and the FIFO can
  // only drain while a command waits, so the free-space term stays safe.
  always_comb begin
    remain   = last_q - curr_q + CW'(1);
    die_room = DIE_SIZE - CW'(curr_q[DIE_ADDR_W-1:0]);
    credit   = CW'(FIFO_DEPTH) - CW'(level_q);
    len_w    = CW'(MAX_BURST);
    if (remain < len_w)   len_w = remain;
    if (die_room < len_w) len_w = die_room;
    if (credit < len_w)   len_w = credit;
    issue_len = LEN_W'(len_w);
  end

  always_comb begin
    state_d      = state_q;
    curr_d       = curr_q;
    last_d       = last_q;
    mode_d       = mode_q;
    rx_cnt_d     = rx_cnt_q;
    abort_pend_d = abort_pend_q;
    err_d        = 1'b0;
    finish_d     = 1'b0;
    cmd_valid_d  = cmd_valid_q;
    cmd_die_d    = cmd_die_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_len_d    = cmd_len_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_flag) begin
          curr_d       = {1'b0, start_addr};
          last_d       = {1'b0, end_addr};
          mode_d       = mode;
          abort_pend_d = 1'b0;
          state_d      = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((mode_q == 2'd3) || (curr_q > last_q) || (last_q >= TOTAL_BYTES)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_valid_q) begin
          // A handshake in the same cycle as abort wins: the controller has
          // the command, so the burst is collected and the abort applied after.
          if (cmd_ready) begin
            cmd_valid_d  = 1'b0;
            curr_d       = curr_q + CW'(cmd_len_q);
            rx_cnt_d     = cmd_len_q;
            abort_pend_d = abort;
            state_d      = S_WAIT_DATA;
          end else if (abort) begin
            cmd_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end else if (abort) begin
          state_d = S_IDLE;
        end else if (issue_len != '0) begin
          cmd_valid_d = 1'b1;
          cmd_len_d   = issue_len;
          cmd_die_d   = curr_q[DIE_ADDR_W +: DIE_W];
          cmd_addr_d  = curr_q[DIE_ADDR_W-1:0];
        end
      end
      S_WAIT_DATA: begin
        if (abort) abort_pend_d = 1'b1;
        if (rx_valid) begin
          rx_cnt_d = rx_cnt_q - LEN_W'(1);
          if (rx_last || (rx_cnt_q == LEN_W'(1))) begin
            if (abort_pend_q || abort) begin
              state_d = S_IDLE;
            end else if (curr_q > last_q) begin
              finish_d = 1'b1;
              state_d  = S_DONE;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      state_q      <= S_IDLE;
      curr_q       <= '0;
      last_q       <= '0;
      mode_q       <= '0;
      rx_cnt_q     <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
      err_q        <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_die_q    <= '0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      curr_q       <= curr_d;
      last_q       <= last_d;
      mode_q       <= mode_d;
      rx_cnt_q     <= rx_cnt_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      finish_q     <= finish_d;
      err_q        <= err_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_die_q    <= cmd_die_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
    end
  end

  // Storage has no reset; emptiness is tracked by the pointers and level.
  always_ff @(posedge system_clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  push_while_full: assert property (@(posedge system_clk) disable iff (system_reset)
    !(push_req && full_w));

  assign busy         = busy_q;
  assign read_finish  = finish_q;
  assign err          = err_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_die      = cmd_die_q;
  assign cmd_addr     = cmd_addr_q;
  assign cmd_len      = cmd_len_q;
  assign cmd_mode     = mode_q;
  assign fifo_dataOut = dout_q;
  assign empty        = empty_w;
  assign full         = full_w;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
// Directed bench for spi_flash_burst_reader with default parameters.
// The controller side is played by tasks; returned byte = low byte of the
// global address it was read from, so FIFO order is checked against a
// running expected address.
module tb_spi_flash_burst_reader;

  localparam int ADDR_W     = 32;
  localparam int DIE_ADDR_W = 25;
  localparam int DIE_CNT    = 2;
  localparam int MAX_BURST  = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int DIE_W      = 1;
  localparam int LEN_W      = 5;
  localparam int LVL_W      = 7;

  logic                  clk = 1'b0;
  logic                  system_reset;
  logic                  start_flag;
  logic [ADDR_W-1:0]     start_addr;
  logic [ADDR_W-1:0]     end_addr;
  logic [1:0]            mode;
  logic                  abort;
  logic                  busy;
  logic                  read_finish;
  logic                  err;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DIE_W-1:0]      cmd_die;
  logic [DIE_ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]      cmd_len;
  logic [1:0]            cmd_mode;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_last;
  logic                  read_req;
  logic [7:0]            fifo_dataOut;
  logic                  empty;
  logic                  full;
  logic [LVL_W-1:0]      fifo_level;

  spi_flash_burst_reader #(
    .ADDR_W    (ADDR_W),
    .DIE_ADDR_W(DIE_ADDR_W),
    .DIE_CNT   (DIE_CNT),
    .MAX_BURST (MAX_BURST),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .system_clk  (clk),
    .system_reset(system_reset),
    .start_flag  (start_flag),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .mode        (mode),
    .abort       (abort),
    .busy        (busy),
    .read_finish (read_finish),
    .err         (err),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_die     (cmd_die),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_mode    (cmd_mode),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_last     (rx_last),
    .read_req    (read_req),
    .fifo_dataOut(fifo_dataOut),
    .empty       (empty),
    .full        (full),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fin_cnt = 0;
  int err_cnt = 0;
  int fin0;
  int err0;
  logic [31:0] exp_next;

  // Registered pulses are stable at the rising edge, so counting there is exact.
  always @(posedge clk) begin
    if (read_finish === 1'b1) fin_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_finish"},    read_finish, 0);
    check({tag, "_err"},       err, 0);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_cmd_die"},   cmd_die, 0);
    check({tag, "_cmd_addr"},  cmd_addr, 0);
    check({tag, "_cmd_len"},   cmd_len, 0);
    check({tag, "_cmd_mode"},  cmd_mode, 0);
    check({tag, "_dout"},      fifo_dataOut, 0);
    check({tag, "_empty"},     empty, 1);
    check({tag, "_full"},      full, 0);
    check({tag, "_level"},     fifo_level, 0);
  endtask

  task automatic start_read(input logic [31:0] s, input logic [31:0] e, input logic [1:0] m);
    start_addr = s;
    end_addr   = e;
    mode       = m;
    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_cmd(input logic [DIE_W-1:0] die, input logic [DIE_ADDR_W-1:0] addr,
                          input logic [LEN_W-1:0] len, input logic [1:0] m);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("cmd_wait_in_budget", n < 200, 1);
    check("cmd_die",  cmd_die, die);
    check("cmd_addr", cmd_addr, addr);
    check("cmd_len",  cmd_len, len);
    check("cmd_mode", cmd_mode, m);
  endtask

  // Accept the pending command, then return nsend of its len bytes.
  task automatic serve(input logic [31:0] base, input int len, input int nsend, input int abort_at);
    logic [31:0] a;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("cmd_valid_after_handshake", cmd_valid, 0);
    for (int i = 0; i < nsend; i++) begin
      a        = base + 32'(i);
      rx_valid = 1'b1;
      rx_data  = a[7:0];
      rx_last  = (i == len - 1);
      abort    = (i == abort_at);
      tick();
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      read_req = 1'b1;
      tick();
      check("fifo_data", fifo_dataOut, exp_next[7:0]);
      exp_next = exp_next + 32'd1;
    end
    read_req = 1'b0;
  endtask

  initial begin
    system_reset = 1'b1;
    start_flag   = 1'b0;
    start_addr   = '0;
    end_addr     = '0;
    mode         = '0;
    abort        = 1'b0;
    cmd_ready    = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = '0;
    rx_last      = 1'b0;
    read_req     = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    system_reset = 1'b0;
    tick();

    // 1: two 16-byte quad bursts in die 0
    fin0 = fin_cnt;
    start_read(32'h10, 32'h2F, 2'd2);
    wait_cmd(0, 25'h10, 16, 2'd2);
    serve(32'h10, 16, 16, -1);
    wait_cmd(0, 25'h20, 16, 2'd2);
    serve(32'h20, 16, 16, -1);
    check("t1_finish", read_finish, 1);
    tick();
    check("t1_finish_low", read_finish, 0);
    check("t1_busy_low", busy, 0);
    check("t1_level", fifo_level, 32);
    check("t1_finish_count", fin_cnt - fin0, 1);
    exp_next = 32'h10;
    drain(32);
    check("t1_empty", empty, 1);

    // 2: die boundary split
    start_read(32'h1FFFFF8, 32'h2000007, 2'd2);
    wait_cmd(0, 25'h1FFFFF8, 8, 2'd2);
    serve(32'h1FFFFF8, 8, 8, -1);
    wait_cmd(1, 25'h0, 8, 2'd2);
    serve(32'h2000000, 8, 8, -1);
    check("t2_finish", read_finish, 1);
    tick();
    exp_next = 32'h1FFFFF8;
    drain(16);

    // 3: FIFO credit limits bursts
    fin0 = fin_cnt;
    start_read(32'h0, 32'h7F, 2'd0);
    for (int b = 0; b < 4; b++) begin
      wait_cmd(0, 25'(b * 16), 16, 2'd0);
      serve(32'(b * 16), 16, 16, -1);
    end
    repeat (5) tick();
    check("t3_no_cmd_when_full", cmd_valid, 0);
    check("t3_full", full, 1);
    check("t3_level_full", fifo_level, 64);
    check("t3_busy", busy, 1);
    exp_next = 32'h0;
    drain(1);
    wait_cmd(0, 25'h40, 1, 2'd0);
    drain(15);
    check("t3_cmd_held_valid", cmd_valid, 1);
    check("t3_cmd_held_len", cmd_len, 1);
    check("t3_level_48", fifo_level, 48);
    serve(32'h40, 1, 1, -1);
    wait_cmd(0, 25'h41, 15, 2'd0);
    serve(32'h41, 15, 15, -1);
    check("t3_level_refull", fifo_level, 64);
    drain(48);
    wait_cmd(0, 25'h50, 1, 2'd0);
    serve(32'h50, 1, 1, -1);
    wait_cmd(0, 25'h51, 16, 2'd0);
    serve(32'h51, 16, 16, -1);
    wait_cmd(0, 25'h61, 16, 2'd0);
    serve(32'h61, 16, 16, -1);
    wait_cmd(0, 25'h71, 15, 2'd0);
    serve(32'h71, 15, 15, -1);
    check("t3_finish", read_finish, 1);
    check("t3_full_end", full, 1);
    tick();
    check("t3_finish_count", fin_cnt - fin0, 1);
    drain(64);
    check("t3_empty", empty, 1);

    // 4: rejected starts
    err0 = err_cnt;
    start_read(32'h0, 32'h10, 2'd3);
    tick();
    check("t4a_err", err, 1);
    check("t4a_busy", busy, 0);
    check("t4a_cmd_valid", cmd_valid, 0);
    tick();
    check("t4a_err_low", err, 0);
    start_read(32'h20, 32'h10, 2'd0);
    tick();
    check("t4b_err", err, 1);
    check("t4b_busy", busy, 0);
    check("t4b_cmd_valid", cmd_valid, 0);
    tick();
    start_read(32'h0, 32'h4000000, 2'd2);
    tick();
    check("t4c_err", err, 1);
    check("t4c_busy", busy, 0);
    check("t4c_cmd_valid", cmd_valid, 0);
    tick();
    check("t4_err_count", err_cnt - err0, 3);

    // 5a: abort while the command is held
    fin0 = fin_cnt;
    start_read(32'h0, 32'hF, 2'd1);
    wait_cmd(0, 25'h0, 16, 2'd1);
    repeat (2) tick();
    check("t5a_cmd_held", cmd_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5a_cmd_drop", cmd_valid, 0);
    check("t5a_busy", busy, 0);
    repeat (3) tick();
    check("t5a_cmd_stays_low", cmd_valid, 0);
    check("t5a_level", fifo_level, 0);

    // 5b: abort mid-burst; the burst is still stored, no second burst
    start_read(32'h100, 32'h11F, 2'd2);
    wait_cmd(0, 25'h100, 16, 2'd2);
    serve(32'h100, 16, 16, 4);
    check("t5b_busy", busy, 0);
    check("t5b_finish", read_finish, 0);
    check("t5b_level", fifo_level, 16);
    repeat (4) tick();
    check("t5b_no_cmd", cmd_valid, 0);
    check("t5_finish_count", fin_cnt - fin0, 0);
    exp_next = 32'h100;
    drain(16);

    // 6: reset mid-burst, then a normal read
    start_read(32'h200, 32'h20F, 2'd2);
    wait_cmd(0, 25'h200, 16, 2'd2);
    serve(32'h200, 16, 10, -1);
    check("t6_level10", fifo_level, 10);
    system_reset = 1'b1;
    tick();
    check_idle_outputs("t6_reset");
    system_reset = 1'b0;
    tick();
    start_read(32'h300, 32'h305, 2'd1);
    wait_cmd(0, 25'h300, 6, 2'd1);
    serve(32'h300, 6, 6, -1);
    check("t6_finish", read_finish, 1);
    tick();
    exp_next = 32'h300;
    drain(6);
    check("t6_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
